// File: rtl/aes_round_key_gen.sv
// Sequential AES-128 key schedule streaming round keys 0..10 over valid/ready.
// Optional reverse-order (decrypt) emission via a key store: define AES_KEYEXP_DEC_EN.
module aes_round_key_gen #(
    parameter int          NR    = 10,
    parameter logic [7:0]  RCON0 = 8'h01
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  key_in,
    input  logic          start,
    input  logic          dec_mode,
    output logic          busy,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [31:0]   K0_out,
    output logic [31:0]   K1_out,
    output logic [31:0]   K2_out,
    output logic [31:0]   K3_out,
    output logic [3:0]    rk_round,
    output logic          done
);

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b sits at bit 8*(255-b)+7, which is simply {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b111};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1
`ifdef AES_KEYEXP_DEC_EN
        , GEN = 2'd2
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     round_q, round_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           done_q, done_d;
    logic [127:0]   step_key;
    logic [31:0]    t_word, n0, n1, n2, n3;
    logic           is_dec;

`ifdef AES_KEYEXP_DEC_EN
    logic           dec_q, dec_d;
    logic [127:0]   store_q [0:NR];
    logic           store_we;
    logic [3:0]     store_idx;
    logic [127:0]   store_wdata;
    assign is_dec = dec_q;
`else
    logic           unused_dec_mode;
    assign unused_dec_mode = dec_mode;
    assign is_dec = 1'b0;
`endif

    // One forward key-schedule step from the currently held round key.
    always_comb begin
        t_word   = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0};
        n0       = key_q[127:96] ^ t_word;
        n1       = key_q[95:64] ^ n0;
        n2       = key_q[63:32] ^ n1;
        n3       = key_q[31:0] ^ n2;
        step_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
`ifdef AES_KEYEXP_DEC_EN
        dec_d       = dec_q;
        store_we    = 1'b0;
        store_idx   = 4'd0;
        store_wdata = key_in;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    rcon_d  = RCON0;
                    state_d = EMIT;
`ifdef AES_KEYEXP_DEC_EN
                    dec_d    = dec_mode;
                    store_we = dec_mode;
                    if (dec_mode) state_d = GEN;
`endif
                end
            end
`ifdef AES_KEYEXP_DEC_EN
            // The working register ends GEN holding key NR, ready to present first.
            GEN: begin
                key_d       = step_key;
                round_d     = round_q + 4'd1;
                rcon_d      = xtime(rcon_q);
                store_we    = 1'b1;
                store_idx   = round_q + 4'd1;
                store_wdata = step_key;
                if (round_q == LAST - 4'd1) state_d = EMIT;
            end
`endif
            EMIT: begin
                if (rk_ready) begin
                    if (is_dec ? (round_q == 4'd0) : (round_q == LAST)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (is_dec) begin
`ifdef AES_KEYEXP_DEC_EN
                        key_d   = store_q[round_q - 4'd1];
`endif
                        round_d = round_q - 4'd1;
                    end else begin
                        key_d   = step_key;
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
            rcon_q  <= RCON0;
            done_q  <= 1'b0;
`ifdef AES_KEYEXP_DEC_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
`ifdef AES_KEYEXP_DEC_EN
            dec_q   <= dec_d;
`endif
        end
    end

`ifdef AES_KEYEXP_DEC_EN
    always_ff @(posedge clk) begin
        if (store_we) store_q[store_idx] <= store_wdata;
    end
`endif

    assign busy     = (state_q != IDLE);
    assign rk_valid = (state_q == EMIT);
    assign K0_out   = key_q[127:96];
    assign K1_out   = key_q[95:64];
    assign K2_out   = key_q[63:32];
    assign K3_out   = key_q[31:0];
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Self-checking bench for aes_round_key_gen: randomized keys and ready stalls
// against a GF(2^8)-derived FIPS-197 key expansion model.
module tb_aes_round_key_gen;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [127:0]  key_in;
   logic          start;
   logic          dec_mode;
   logic          busy;
   logic          rk_valid;
   logic          rk_ready;
   logic [31:0]   K0_out, K1_out, K2_out, K3_out;
   logic [3:0]    rk_round;
   logic          done;

   int            checks = 0;
   int            failures = 0;
   logic [7:0]    sboxRef [0:255];
   logic [127:0]  refKeys [0:10];
   logic [127:0]  dutKeys [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   aes_round_key_gen dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key_in),
      .start    (start),
      .dec_mode (dec_mode),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .K0_out   (K0_out),
      .K1_out   (K1_out),
      .K2_out   (K2_out),
      .K3_out   (K3_out),
      .rk_round (rk_round),
      .done     (done)
   );

   // Free-running clock; the bench samples and drives on falling edges.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [135:0] got, input logic [135:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse (a^254) then affine map.
   task automatic buildSbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h01;
         logic [7:0] av  = 8'(a);
         if (a == 0) inv = 8'h00;
         else for (int k = 0; k < 254; k++) inv = gmul(inv, av);
         sboxRef[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Textbook 44-word key expansion into eleven 128-bit round keys.
   task automatic computeRef(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] temp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         temp = w[i-1];
         if (i % 4 == 0) begin
            temp = {temp[23:0], temp[31:24]};
            temp = {sboxRef[temp[31:24]], sboxRef[temp[23:16]], sboxRef[temp[15:8]], sboxRef[temp[7:0]]};
            temp = temp ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ temp;
      end
      for (int r = 0; r <= 10; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Pulses start for one cycle, then scrambles key_in to prove it is not re-sampled.
   task automatic applyStimulus(input logic [127:0] key, input logic dec);
      key_in   = key;
      dec_mode = dec;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dec_mode = ~dec;
      key_in   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // poke: 0 none, 1 = ignored restart at round 4, 2 = reset at round 6.
   task automatic runStream(input logic [127:0] key, input int readyPct, input int poke, input logic dec);
      int count = 0;
      int cycles = 0;
      int expIdx;
      logic rdy;
      computeRef(key);
      applyStimulus(key, dec);
      if (dec) begin
         for (int i = 0; i < 10; i++) begin
            checkOutput("gen_wait", {134'h0, rk_valid, busy}, 136'b01);
            @(negedge clk);
         end
      end
      while (count <= 10 && cycles < 200) begin
         expIdx = dec ? 10 - count : count;
         checkOutput("round_key", {3'b0, rk_valid, rk_round, K0_out, K1_out, K2_out, K3_out},
                     {3'b0, 1'b1, 4'(expIdx), refKeys[expIdx]});
         if (poke == 2 && count == 6) begin
            rst_n = 1'b0;
            #1;
            checkOutput("mid_reset", {3'b0, rk_valid, busy, done, rk_round, K0_out, K1_out, K2_out, K3_out}, 136'h0);
            rk_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (poke == 1 && count == 4) begin
            start  = 1'b1;
            key_in = ~key;
         end
         rdy = ($urandom_range(99) < readyPct);
         rk_ready = rdy;
         if (rdy) dutKeys[expIdx] = {K0_out, K1_out, K2_out, K3_out};
         @(negedge clk);
         start = 1'b0;
         cycles++;
         if (rdy) count++;
      end
      if (count <= 10) checkOutput("stream_timeout", 136'(count), 136'd11);
      rk_ready = 1'b0;
      checkOutput("end_flags", {133'h0, done, busy, rk_valid}, 136'b100);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; dec_mode = 1'b0; key_in = '0; rk_ready = 1'b0;
      buildSbox();
      repeat (2) @(negedge clk);
      checkOutput("reset_state", {3'b0, rk_valid, busy, done, rk_round, K0_out, K1_out, K2_out, K3_out}, 136'h0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_after_reset", {133'h0, rk_valid, busy, done}, 136'h0);

      runStream(FIPS_KEY, 100, 0, 1'b0);
      checkOutput("fips_r0", 136'(dutKeys[0]), 136'(FIPS_KEY));
      checkOutput("fips_r1", 136'(dutKeys[1]), 136'h00a0fafe1788542cb123a339392a6c7605);
      checkOutput("fips_r10", 136'(dutKeys[10]), 136'h00d014f9a8c9ee2589e13f0cc8b6630ca6);
      @(negedge clk);
      checkOutput("done_one_cycle", {134'h0, done, busy}, 136'h0);

      repeat (3) runStream(FIPS_KEY, 50, 0, 1'b0);
      runStream(FIPS_KEY, 60, 1, 1'b0);
      runStream(FIPS_KEY, 100, 2, 1'b0);
      runStream(FIPS_KEY, 100, 0, 1'b0);

      runStream(128'h0, 100, 0, 1'b0);
      checkOutput("zero_r1", 136'(dutKeys[1]), 136'h0062636363626363636263636362636363);
      checkOutput("zero_r10", 136'(dutKeys[10]), 136'h00b4ef5bcb3e92e21123e951cf6f8f188e);

      // Second stream starts in the very cycle the first one's done is high.
      runStream({$urandom, $urandom, $urandom, $urandom}, 70, 0, 1'b0);
      runStream({$urandom, $urandom, $urandom, $urandom}, 70, 0, 1'b0);
      repeat (2) @(negedge clk);

`ifdef AES_KEYEXP_DEC_EN
      runStream(FIPS_KEY, 100, 0, 1'b1);
      checkOutput("dec_r10", 136'(dutKeys[10]), 136'h00d014f9a8c9ee2589e13f0cc8b6630ca6);
      checkOutput("dec_r0", 136'(dutKeys[0]), 136'(FIPS_KEY));
      runStream({$urandom, $urandom, $urandom, $urandom}, 50, 0, 1'b1);
      runStream({$urandom, $urandom, $urandom, $urandom}, 60, 0, 1'b0);
      repeat (2) @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
